// File: rtl/pattern_load_write.sv
// Streams a pattern image (header + bit-packed bodies) into DDR3 through a one-deep
// Avalon-MM write holder, bracketing the load with on-chip "loaded" flag writes.
module pattern_load_write (
  input  logic         ddr3_emif_clk,
  input  logic         ddr3_emif_rst_n,
  input  logic         start,
  input  logic         s_valid,
  input  logic [255:0] s_data,
  output logic         s_ready,
  input  logic         ddr3_emif_ready,
  output logic         ddr3_emif_write,
  output logic         ddr3_emif_read,
  output logic [21:0]  ddr3_emif_addr,
  output logic [255:0] ddr3_emif_write_data,
  output logic [31:0]  ddr3_emif_byte_enable,
  output logic [4:0]   ddr3_emif_burst_count,
  output logic         onchip_mem_clken,
  output logic         onchip_mem_chip_select,
  output logic         onchip_mem_write,
  output logic [10:0]  onchip_mem_addr,
  output logic [255:0] onchip_mem_write_data,
  output logic [31:0]  onchip_mem_byte_enable,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int DATA_W = 256;
  localparam int ADDR_W = 22;
  localparam logic [DATA_W-1:0] FLAG_CLEAR  = '0;
  localparam logic [DATA_W-1:0] FLAG_LOADED = 256'h55;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR_FLAG = 3'd1,
    HEAD     = 3'd2,
    BODY     = 3'd3,
    SET_FLAG = 3'd4
  } state_t;

  state_t              state_q;
  logic                pending_q;
  logic                drain_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [23:0]         word_cnt_q;
  logic [23:0]         body_words_q;
  logic [31:0]         pat_cnt_q;
  logic                err_q;
  logic                done_q;
  logic                busy_q;
  logic                fl_en_q;
  logic [DATA_W-1:0]   fl_data_q;
  logic [31:0]         fl_be_q;

  logic                accept;
  logic                complete;
  logic [31:0]         hdr_total_pix;
  logic [31:0]         hdr_pat_num;
  logic [23:0]         hdr_body_words;

  assign hdr_total_pix  = s_data[191:160];
  assign hdr_pat_num    = s_data[159:128];
  // One bit per pixel: a partial trailing byte-group of 256 pixels still costs a full word.
  assign hdr_body_words = hdr_total_pix[31:8] + {23'd0, |hdr_total_pix[7:0]};

  // drain_q closes the input once the last word of the image (or a bad header) is taken.
  assign s_ready  = ((state_q == HEAD) || (state_q == BODY)) && !drain_q &&
                    (!pending_q || ddr3_emif_ready);
  assign accept   = s_valid && s_ready;
  assign complete = pending_q && ddr3_emif_ready;

  always_ff @(posedge ddr3_emif_clk) begin
    if (!ddr3_emif_rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      drain_q      <= 1'b0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_cnt_q   <= '0;
      body_words_q <= '0;
      pat_cnt_q    <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      fl_en_q      <= 1'b0;
      fl_data_q    <= '0;
      fl_be_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      fl_en_q   <= 1'b0;
      fl_data_q <= '0;
      fl_be_q   <= '0;

      // Write engine: the counter tracks the address of the held (or next) word.
      if (complete) begin
        cnt_q <= cnt_q + 22'd1;
        if (cnt_q == '1) begin
          err_q <= 1'b1;
        end
      end
      if (accept) begin
        pending_q <= 1'b1;
        wr_data_q <= s_data;
        wr_addr_q <= complete ? cnt_q + 22'd1 : cnt_q;
      end else if (complete) begin
        pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= CLR_FLAG;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            fl_en_q   <= 1'b1;
            fl_data_q <= FLAG_CLEAR;
            fl_be_q   <= '1;
          end
        end
        CLR_FLAG: begin
          state_q <= HEAD;
        end
        HEAD, BODY: begin
          if (drain_q) begin
            if (!pending_q) begin
              state_q   <= SET_FLAG;
              drain_q   <= 1'b0;
              done_q    <= 1'b1;
              fl_en_q   <= 1'b1;
              fl_data_q <= FLAG_LOADED;
              fl_be_q   <= '1;
            end
          end else if (accept && (state_q == HEAD)) begin
            body_words_q <= hdr_body_words;
            pat_cnt_q    <= hdr_pat_num;
            word_cnt_q   <= '0;
            if ((hdr_pat_num == 32'd0) || (hdr_total_pix == 32'd0)) begin
              err_q   <= 1'b1;
              drain_q <= 1'b1;
            end else begin
              state_q <= BODY;
            end
          end else if (accept) begin
            if (word_cnt_q == body_words_q - 24'd1) begin
              word_cnt_q <= '0;
              pat_cnt_q  <= pat_cnt_q - 32'd1;
              if (pat_cnt_q == 32'd1) begin
                drain_q <= 1'b1;
              end
            end else begin
              word_cnt_q <= word_cnt_q + 24'd1;
            end
          end
        end
        SET_FLAG: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          drain_q <= 1'b0;
        end
      endcase
    end
  end

  assign ddr3_emif_write        = pending_q;
  assign ddr3_emif_read         = 1'b0;
  assign ddr3_emif_addr         = wr_addr_q;
  assign ddr3_emif_write_data   = wr_data_q;
  assign ddr3_emif_byte_enable  = '1;
  assign ddr3_emif_burst_count  = 5'd1;

  assign onchip_mem_clken       = fl_en_q;
  assign onchip_mem_chip_select = fl_en_q;
  assign onchip_mem_write       = fl_en_q;
  assign onchip_mem_addr        = '0;
  assign onchip_mem_write_data  = fl_data_q;
  assign onchip_mem_byte_enable = fl_be_q;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_pattern_load_write.sv
// Directed bench for pattern_load_write: streams headers and bodies, records DDR3 and
// on-chip flag writes at the falling edge and compares them with hand-derived values.
module tb_pattern_load_write;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         s_valid;
  logic [255:0] s_data;
  logic         s_ready;
  logic         ddr3_emif_ready;
  logic         ddr3_emif_write;
  logic         ddr3_emif_read;
  logic [21:0]  ddr3_emif_addr;
  logic [255:0] ddr3_emif_write_data;
  logic [31:0]  ddr3_emif_byte_enable;
  logic [4:0]   ddr3_emif_burst_count;
  logic         onchip_mem_clken;
  logic         onchip_mem_chip_select;
  logic         onchip_mem_write;
  logic [10:0]  onchip_mem_addr;
  logic [255:0] onchip_mem_write_data;
  logic [31:0]  onchip_mem_byte_enable;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [21:0]  wq_addr[$];
  logic [255:0] wq_data[$];
  logic [255:0] fq_data[$];
  int           done_cnt = 0;
  bit           rand_en = 1'b0;

  always #5 clk = ~clk;

  pattern_load_write dut (
    .ddr3_emif_clk          (clk),
    .ddr3_emif_rst_n        (rst_n),
    .start                  (start),
    .s_valid                (s_valid),
    .s_data                 (s_data),
    .s_ready                (s_ready),
    .ddr3_emif_ready        (ddr3_emif_ready),
    .ddr3_emif_write        (ddr3_emif_write),
    .ddr3_emif_read         (ddr3_emif_read),
    .ddr3_emif_addr         (ddr3_emif_addr),
    .ddr3_emif_write_data   (ddr3_emif_write_data),
    .ddr3_emif_byte_enable  (ddr3_emif_byte_enable),
    .ddr3_emif_burst_count  (ddr3_emif_burst_count),
    .onchip_mem_clken       (onchip_mem_clken),
    .onchip_mem_chip_select (onchip_mem_chip_select),
    .onchip_mem_write       (onchip_mem_write),
    .onchip_mem_addr        (onchip_mem_addr),
    .onchip_mem_write_data  (onchip_mem_write_data),
    .onchip_mem_byte_enable (onchip_mem_byte_enable),
    .busy                   (busy),
    .done                   (done),
    .err                    (err)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] hdr(input logic [31:0] tp, input logic [31:0] pat);
    return {32'd640, 32'd480, tp, pat, 32'd0, 32'd0, 32'd0, 32'd0};
  endfunction

  function automatic logic [255:0] body(input int i);
    return {32'hCAFE0000 + 32'(i), 192'h0, 32'hB0DA0000 + 32'(i)};
  endfunction

  // Falling-edge monitor: inputs only change just after the rising edge, so what is seen
  // here is exactly what the next rising edge samples.
  logic         hold_vld = 1'b0;
  logic [21:0]  hold_addr;
  logic [255:0] hold_data;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_vld) begin
        check("hold_write", ddr3_emif_write, 1'b1);
        check("hold_addr", ddr3_emif_addr, hold_addr);
        check("hold_data", ddr3_emif_write_data, hold_data);
      end
      hold_vld = ddr3_emif_write && !ddr3_emif_ready;
      hold_addr = ddr3_emif_addr;
      hold_data = ddr3_emif_write_data;
      if (ddr3_emif_write && ddr3_emif_ready) begin
        wq_addr.push_back(ddr3_emif_addr);
        wq_data.push_back(ddr3_emif_write_data);
      end
      if (onchip_mem_write) begin
        fq_data.push_back(onchip_mem_write_data);
        check("flag_cs", onchip_mem_chip_select, 1'b1);
        check("flag_be", onchip_mem_byte_enable, 32'hFFFF_FFFF);
        check("flag_addr", onchip_mem_addr, 11'd0);
      end
      if (done) done_cnt++;
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) ddr3_emif_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    fq_data.delete();
    done_cnt = 0;
  endtask

  task automatic send_word(input logic [255:0] w);
    bit acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data = w;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("word_accepted", acc, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check(tag, found, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input int n, input logic [21:0] base,
                              input logic [255:0] hw);
    logic [21:0] a;
    check({tag, "_count"}, wq_addr.size(), n);
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      a = base + 22'(i);
      check({tag, "_addr"}, wq_addr[i], a);
      check({tag, "_data"}, wq_data[i], (i == 0) ? hw : body(i));
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_flag_count"}, fq_data.size(), 2);
    if (fq_data.size() == 2) begin
      check({tag, "_flag_clr"}, fq_data[0], 256'h0);
      check({tag, "_flag_set"}, fq_data[1], 256'h55);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    ddr3_emif_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_write", ddr3_emif_write, 1'b0);
    check("rst_addr", ddr3_emif_addr, 22'd0);
    check("rst_wdata", ddr3_emif_write_data, 256'h0);
    check("rst_onchip_write", onchip_mem_write, 1'b0);
    check("rst_onchip_be", onchip_mem_byte_enable, 32'h0);
    check("tie_read", ddr3_emif_read, 1'b0);
    check("tie_burst", ddr3_emif_burst_count, 5'd1);
    check("tie_be", ddr3_emif_byte_enable, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;

    // Basic load: 512 pixels -> 2 words per pattern, 2 patterns, header held before start.
    clear_log();
    s_valid = 1'b1;
    s_data = hdr(32'd512, 32'd2);
    repeat (2) begin
      @(negedge clk);
      check("idle_s_ready", s_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    pulse_start();
    @(negedge clk);
    check("clr_busy", busy, 1'b1);
    check("clr_flag_data", onchip_mem_write_data, 256'h0);
    @(posedge clk);
    #1;
    send_word(hdr(32'd512, 32'd2));
    for (int i = 1; i <= 4; i++) send_word(body(i));
    wait_done("t1_done");
    check_writes("t1", 5, 22'd0, hdr(32'd512, 32'd2));
    check_flags("t1");
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err", err, 1'b0);
    check("t1_busy_after", busy, 1'b0);

    // 300 pixels -> 2 words, one pattern, ready randomly stalling.
    clear_log();
    rand_en = 1'b1;
    pulse_start();
    send_word(hdr(32'd300, 32'd1));
    send_word(body(1));
    send_word(body(2));
    wait_done("t2_done");
    rand_en = 1'b0;
    ddr3_emif_ready = 1'b1;
    check_writes("t2", 3, 22'd0, hdr(32'd300, 32'd1));
    check_flags("t2");
    check("t2_done_cnt", done_cnt, 1);
    check("t2_err", err, 1'b0);

    // Zero patterns: header only, error flagged, flag still written, extra word refused.
    clear_log();
    pulse_start();
    send_word(hdr(32'd512, 32'd0));
    s_valid = 1'b1;
    s_data = body(1);
    wait_done("t3_done");
    @(negedge clk);
    check("t3_s_ready_idle", s_ready, 1'b0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check_writes("t3", 1, 22'd0, hdr(32'd512, 32'd0));
    check_flags("t3");
    check("t3_err", err, 1'b1);
    check("t3_done_cnt", done_cnt, 1);

    // Reset with two writes complete and a third held by a stalled slave.
    clear_log();
    pulse_start();
    send_word(hdr(32'd512, 32'd2));
    send_word(body(1));
    send_word(body(2));
    ddr3_emif_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_pending_before", ddr3_emif_write, 1'b1);
    @(negedge clk);
    check("t4_write", ddr3_emif_write, 1'b0);
    check("t4_addr", ddr3_emif_addr, 22'd0);
    check("t4_wdata", ddr3_emif_write_data, 256'h0);
    check("t4_busy", busy, 1'b0);
    check("t4_s_ready", s_ready, 1'b0);
    check("t4_onchip", onchip_mem_write, 1'b0);
    check("t4_writes_done", wq_addr.size(), 2);
    check("t4_flags", fq_data.size(), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ddr3_emif_ready = 1'b1;
    clear_log();
    pulse_start();
    send_word(hdr(32'd512, 32'd2));
    for (int i = 1; i <= 4; i++) send_word(body(i));
    wait_done("t4_done");
    check_writes("t4r", 5, 22'd0, hdr(32'd512, 32'd2));
    check_flags("t4r");

    // Start pulsed mid-body must not disturb the run.
    clear_log();
    pulse_start();
    send_word(hdr(32'd512, 32'd2));
    send_word(body(1));
    pulse_start();
    for (int i = 2; i <= 4; i++) send_word(body(i));
    wait_done("t5_done");
    check_writes("t5", 5, 22'd0, hdr(32'd512, 32'd2));
    check_flags("t5");
    check("t5_done_cnt", done_cnt, 1);

    // Counter placed just below the top of the address space before the header lands.
    clear_log();
    pulse_start();
    force dut.cnt_q = 22'h3FFFFE;
    #1;
    release dut.cnt_q;
    send_word(hdr(32'd512, 32'd2));
    for (int i = 1; i <= 4; i++) send_word(body(i));
    wait_done("t6_done");
    check_writes("t6", 5, 22'h3FFFFE, hdr(32'd512, 32'd2));
    check_flags("t6");
    check("t6_err", err, 1'b1);
    check("t6_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
